sprite_button_renderer: RTL and testbench
=========================================

// Module: sprite_button_renderer
// PURPOSE
//  Parametrised, pipelined sprite renderer for sequencer pad buttons, placed at (BtnX,BtnY).
//  Adds the following over the first-generation renderer:
//   - bounds check, integer scaling and multi-frame sprites (off/on);
//   - palette-index transparency key;
//   - beat-hit flash FSM, latched per video frame to avoid tearing.
//  Sits between the VGA timing generator and the top-level colour mux; one instance per pad.
// PARAMETERS
//  SPR_W        50  sprite width in source pixels
//  SPR_H        50  sprite height in source pixels
//  SCALE_LOG2   0   on-screen scale = 2**SCALE_LOG2 (0..3)
//  ADDR_W       13  ROM address width; must hold 2*SPR_W*SPR_H
//  ROM_LAT      1   ROM read latency in vga_clk cycles (1..2)
//  TRANSP_IDX   0   palette index treated as transparent
//  FLASH_FRAMES 8   frames a hit flash lasts (1..255)
//  FLASH_BOOST  4   per-channel additive brighten during flash (4-bit, saturating)
// PORTS
//  vga_clk      in   1       pixel clock; all state on posedge
//  reset_n      in   1       async active-low reset
//  DrawX,DrawY  in   10      current pixel coordinate
//  BtnX,BtnY    in   10      sprite top-left on screen
//  blank        in   1       1 = active video
//  frame_start  in   1       1-cycle pulse at first pixel of each frame
//  btn_on       in   1       pad state: 0 selects frame 0, 1 selects frame 1
//  hit          in   1       1-cycle pulse when the sequencer plays this pad
//  rom_address  out  ADDR_W  sprite ROM address (registered)
//  rom_q        in   4       palette index, ROM_LAT cycles after rom_address
//  pal_index    out  4       = rom_q, to the external combinational palette
//  pal_r,g,b    in   4 each  palette colour for pal_index
//  sprite_hit   out  1       1 = this pixel is an opaque sprite pixel
//  red,green,blue out 4 each output colour; 0 when sprite_hit=0
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - rom_address, red/green/blue and sprite_hit = 0; pipeline valids = 0;
//   - FSM = IDLE, flash_cnt = 0, on_vis = 0, flash_vis = 0.
//  S0 (register):
//   - offX = DrawX-BtnX, offY = DrawY-BtnY, 10-bit unsigned;
//   - inside = DrawX>=BtnX && offX<(SPR_W<<SCALE_LOG2), and the same for Y;
//   - u = offX>>SCALE_LOG2, v = offY>>SCALE_LOG2;
//   - rom_address = on_vis*SPR_W*SPR_H + v*SPR_W + u, computed ADDR_W wide;
//   - when inside=0, rom_address holds 0;
//   - inside and blank are delayed alongside rom_address.
//  ROM stage: inside/blank delayed ROM_LAT cycles to align with rom_q.
//  Output stage (register):
//   - sprite_hit = blank_d & inside_d & (rom_q != TRANSP_IDX);
//   - rgb = sprite_hit ? pal_rgb : 0;
//   - if flash_vis, each channel = min(15, pal+FLASH_BOOST).
//  Latency: DrawX/DrawY -> red/green/blue/sprite_hit = 2+ROM_LAT cycles, fixed.
//  Flash FSM (IDLE, FLASH):
//   - IDLE + hit -> FLASH, flash_cnt = FLASH_FRAMES;
//   - FLASH + hit -> stay, flash_cnt reloads to FLASH_FRAMES (retrigger);
//   - FLASH + frame_start (no hit) -> flash_cnt-1; reaching 0 -> IDLE;
//   - hit and frame_start in the same cycle: reload wins, no decrement.
//  Frame latch:
//   - on frame_start, on_vis <= btn_on and flash_vis <= (next state == FLASH);
//   - these are the only update points, so a frame is never split.
//  Boundaries:
//   - sprite crossing the right/bottom screen edge: pixels beyond 639/479 are never drawn; no wrap;
//   - BtnX > DrawX never hits, because the DrawX>=BtnX guard blocks unsigned underflow;
//   - blank=0 forces rgb=0 and sprite_hit=0 regardless of flash;
//   - reset mid-frame clears the pipeline; the output is black until refilled.
// TESTING
//  T1 BtnX=100,BtnY=50, scale 0, btn_on=0, ROM idx=5 everywhere:
//     DrawX=100..149,DrawY=50 -> sprite_hit=1 exactly 3 cycles later (ROM_LAT=1);
//     DrawX=99 and DrawX=150 -> 0.
//  T2 btn_on=1 set mid-frame -> addresses stay in 0..2499 until frame_start;
//     then pixel (BtnX,BtnY) reads address 2500.
//  T3 SCALE_LOG2=1 -> 100x100 footprint; offsets (0,0),(1,1) -> addr 0;
//     offset (2,0) -> addr 1; offset (0,2) -> addr 50.
//  T4 idx=TRANSP_IDX inside the sprite -> sprite_hit=0, rgb=0;
//     blank=0 with an opaque pixel -> rgb=0.
//  T5 pal=(13,2,0), hit then frame_start -> rgb=(15,6,4) for 8 frames, then (13,2,0);
//     hit in frame 5 -> the flash extends 8 frames from that point.
//  T6 assert reset_n low in FLASH mid-line -> outputs 0 immediately;
//     after release -> FSM IDLE, no flash, frame 0 until the next frame_start.

Source files
------------

// File: rtl/sprite_button_renderer.sv
// Pipelined sprite renderer for one sequencer pad: bounds/scale address generation,
// palette transparency key, and a frame-latched beat-hit flash.
module sprite_button_renderer #(
  parameter int unsigned SPR_W        = 50,
  parameter int unsigned SPR_H        = 50,
  parameter int unsigned SCALE_LOG2   = 0,
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned ROM_LAT      = 1,
  parameter logic [3:0]  TRANSP_IDX   = 4'd0,
  parameter int unsigned FLASH_FRAMES = 8,
  parameter logic [3:0]  FLASH_BOOST  = 4'd4
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        BtnX,
  input  logic [9:0]        BtnY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              btn_on,
  input  logic              hit,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [3:0]        rom_q,
  output logic [3:0]        pal_index,
  input  logic [3:0]        pal_r,
  input  logic [3:0]        pal_g,
  input  logic [3:0]        pal_b,
  output logic              sprite_hit,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);

  typedef enum logic {ST_IDLE, ST_FLASH} state_t;

  localparam int unsigned       FOOT_W    = SPR_W << SCALE_LOG2;
  localparam int unsigned       FOOT_H    = SPR_H << SCALE_LOG2;
  localparam logic [ADDR_W-1:0] FRAME_SZ  = ADDR_W'(SPR_W * SPR_H);
  localparam logic [ADDR_W-1:0] SPR_W_A   = ADDR_W'(SPR_W);
  localparam logic [7:0]        FLASH_INI = 8'(FLASH_FRAMES);

  logic [9:0]        w_off_x, w_off_y, w_u, w_v;
  logic              w_inside, w_opaque;
  logic [ADDR_W-1:0] w_addr;

  logic               r_inside_s0, r_blank_s0;
  logic [ROM_LAT-1:0] r_inside_d, r_blank_d;
  logic               r_on_vis, r_flash_vis;
  state_t             r_state, w_state_nxt;
  logic [7:0]         r_flash_cnt, w_cnt_nxt;

  // The >= guards stop unsigned underflow from aliasing into the footprint.
  assign w_off_x  = DrawX - BtnX;
  assign w_off_y  = DrawY - BtnY;
  assign w_inside = (DrawX >= BtnX) && (32'(w_off_x) < FOOT_W) &&
                    (DrawY >= BtnY) && (32'(w_off_y) < FOOT_H);
  assign w_u      = w_off_x >> SCALE_LOG2;
  assign w_v      = w_off_y >> SCALE_LOG2;
  assign w_addr   = (r_on_vis ? FRAME_SZ : '0) + ADDR_W'(w_v) * SPR_W_A + ADDR_W'(w_u);

  assign pal_index = rom_q;
  assign w_opaque  = r_blank_d[ROM_LAT-1] & r_inside_d[ROM_LAT-1] & (rom_q != TRANSP_IDX);

  function automatic logic [3:0] boost(input logic [3:0] c);
    logic [4:0] s;
    s = {1'b0, c} + {1'b0, FLASH_BOOST};
    return s[4] ? 4'hF : s[3:0];
  endfunction

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      r_inside_s0 <= 1'b0;
      r_blank_s0  <= 1'b0;
      r_inside_d  <= '0;
      r_blank_d   <= '0;
      sprite_hit  <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      rom_address   <= w_inside ? w_addr : '0;
      r_inside_s0   <= w_inside;
      r_blank_s0    <= blank;
      r_inside_d[0] <= r_inside_s0;
      r_blank_d[0]  <= r_blank_s0;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        r_inside_d[i] <= r_inside_d[i-1];
        r_blank_d[i]  <= r_blank_d[i-1];
      end
      sprite_hit <= w_opaque;
      red        <= w_opaque ? (r_flash_vis ? boost(pal_r) : pal_r) : '0;
      green      <= w_opaque ? (r_flash_vis ? boost(pal_g) : pal_g) : '0;
      blue       <= w_opaque ? (r_flash_vis ? boost(pal_b) : pal_b) : '0;
    end
  end

  // A hit always reloads, so it also masks a same-cycle frame_start decrement.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_flash_cnt;
    if (hit) begin
      w_state_nxt = ST_FLASH;
      w_cnt_nxt   = FLASH_INI;
    end else if (r_state == ST_FLASH && frame_start) begin
      w_cnt_nxt = r_flash_cnt - 8'd1;
      if (r_flash_cnt == 8'd1) w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_flash_cnt <= '0;
      r_on_vis    <= 1'b0;
      r_flash_vis <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flash_cnt <= w_cnt_nxt;
      if (frame_start) begin
        r_on_vis    <= btn_on;
        r_flash_vis <= (w_state_nxt == ST_FLASH);
      end
    end
  end

endmodule

// File: tb/tb_sprite_button_renderer.sv
// Directed bench for sprite_button_renderer: bounds, latency, frame latch, scaling,
// transparency, flash FSM and asynchronous reset.
module tb_sprite_button_renderer;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, BtnX, BtnY;
  logic        blank, frame_start, btn_on, hit;
  logic [12:0] rom_address, rom_address2;
  logic [3:0]  rom_q, rom_q2, pal_index, pal_index2;
  logic [3:0]  pal_r, pal_g, pal_b;
  logic        sprite_hit, sprite_hit2;
  logic [3:0]  red, green, blue, red2, green2, blue2;
  logic        btn_on2;
  logic [3:0]  mem [0:8191];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_q <= mem[rom_address];

  sprite_button_renderer #(.SPR_W(50), .SPR_H(50), .SCALE_LOG2(0), .ADDR_W(13), .ROM_LAT(1),
                           .TRANSP_IDX(4'd0), .FLASH_FRAMES(8), .FLASH_BOOST(4'd4)) u_dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .BtnX(BtnX), .BtnY(BtnY),
    .blank(blank), .frame_start(frame_start), .btn_on(btn_on), .hit(hit),
    .rom_address(rom_address), .rom_q(rom_q), .pal_index(pal_index),
    .pal_r(pal_r), .pal_g(pal_g), .pal_b(pal_b),
    .sprite_hit(sprite_hit), .red(red), .green(green), .blue(blue));

  sprite_button_renderer #(.SPR_W(50), .SPR_H(50), .SCALE_LOG2(1), .ADDR_W(13), .ROM_LAT(1),
                           .TRANSP_IDX(4'd0), .FLASH_FRAMES(8), .FLASH_BOOST(4'd4)) u_dut2 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .BtnX(BtnX), .BtnY(BtnY),
    .blank(blank), .frame_start(frame_start), .btn_on(btn_on2), .hit(hit),
    .rom_address(rom_address2), .rom_q(rom_q2), .pal_index(pal_index2),
    .pal_r(pal_r), .pal_g(pal_g), .pal_b(pal_b),
    .sprite_hit(sprite_hit2), .red(red2), .green(green2), .blue(blue2));

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if (rom_address !== 13'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", rom_address); end
    n_checks++;
    if (sprite_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b expected 0", sprite_hit); end
    n_checks++;
    if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000", {red, green, blue}); end
    reset_n = 1'b1;
    BtnX = 10'd100; BtnY = 10'd50; DrawX = 10'd100; DrawY = 10'd50; blank = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (sprite_hit !== 1'b0 || {red, green, blue} !== 12'h000) begin
      n_fail++; $display("FAIL post_reset_blank: got hit=%b rgb=%h expected hit=0 rgb=000", sprite_hit, {red, green, blue});
    end
  endtask

  task automatic test_bounds();
    logic exp;
    blank = 1'b1; BtnX = 10'd100; BtnY = 10'd50; DrawY = 10'd50; DrawX = 10'd99;
    repeat (3) tick();
    DrawX = 10'd100;
    tick();
    n_checks++;
    if (sprite_hit !== 1'b0) begin n_fail++; $display("FAIL latency_c1: got %b expected 0", sprite_hit); end
    tick();
    n_checks++;
    if (sprite_hit !== 1'b0) begin n_fail++; $display("FAIL latency_c2: got %b expected 0", sprite_hit); end
    tick();
    n_checks++;
    if (sprite_hit !== 1'b1 || {red, green, blue} !== 12'hD20 || pal_index !== 4'd5) begin
      n_fail++; $display("FAIL latency_c3: got hit=%b rgb=%h idx=%0d expected hit=1 rgb=d20 idx=5", sprite_hit, {red, green, blue}, pal_index);
    end
    for (int x = 98; x <= 151; x++) begin
      DrawX = 10'(x);
      repeat (3) tick();
      exp = (x >= 100 && x <= 149);
      n_checks++;
      if (sprite_hit !== exp) begin n_fail++; $display("FAIL sweep_x%0d: got %b expected %b", x, sprite_hit, exp); end
    end
    DrawX = 10'd120;
    for (int y = 49; y <= 100; y++) begin
      if (y == 49 || y == 50 || y == 99 || y == 100) begin
        DrawY = 10'(y);
        repeat (3) tick();
        exp = (y >= 50 && y <= 99);
        n_checks++;
        if (sprite_hit !== exp) begin n_fail++; $display("FAIL edge_y%0d: got %b expected %b", y, sprite_hit, exp); end
      end
    end
    BtnX = 10'd1000; BtnY = 10'd50; DrawX = 10'd5; DrawY = 10'd50;
    repeat (3) tick();
    n_checks++;
    if (sprite_hit !== 1'b0) begin n_fail++; $display("FAIL underflow_x: got %b expected 0", sprite_hit); end
    BtnX = 10'd100; BtnY = 10'd1000; DrawX = 10'd100; DrawY = 10'd10;
    repeat (3) tick();
    n_checks++;
    if (sprite_hit !== 1'b0) begin n_fail++; $display("FAIL underflow_y: got %b expected 0", sprite_hit); end
    BtnX = 10'd620; BtnY = 10'd50; DrawX = 10'd639; DrawY = 10'd50;
    repeat (3) tick();
    n_checks++;
    if (sprite_hit !== 1'b1) begin n_fail++; $display("FAIL right_edge: got %b expected 1", sprite_hit); end
    DrawX = 10'd0;
    repeat (3) tick();
    n_checks++;
    if (sprite_hit !== 1'b0) begin n_fail++; $display("FAIL no_wrap: got %b expected 0", sprite_hit); end
  endtask

  task automatic test_transparency();
    BtnX = 10'd100; BtnY = 10'd50; blank = 1'b1;
    mem[3] = 4'd0;
    DrawX = 10'd103; DrawY = 10'd50;
    repeat (3) tick();
    n_checks++;
    if (sprite_hit !== 1'b0 || {red, green, blue} !== 12'h000 || pal_index !== 4'd0) begin
      n_fail++; $display("FAIL transparent: got hit=%b rgb=%h idx=%0d expected hit=0 rgb=000 idx=0", sprite_hit, {red, green, blue}, pal_index);
    end
    DrawX = 10'd104;
    repeat (3) tick();
    n_checks++;
    if (sprite_hit !== 1'b1) begin n_fail++; $display("FAIL opaque_neighbour: got %b expected 1", sprite_hit); end
    blank = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (sprite_hit !== 1'b0 || {red, green, blue} !== 12'h000) begin
      n_fail++; $display("FAIL blanked: got hit=%b rgb=%h expected hit=0 rgb=000", sprite_hit, {red, green, blue});
    end
    blank = 1'b1;
    mem[3] = 4'd5;
  endtask

  task automatic test_scale();
    int ox [6] = '{0, 1, 2, 0, 99, 100};
    int oy [6] = '{0, 1, 0, 2, 99, 0};
    int ea [6] = '{0, 0, 1, 50, 2499, 0};
    logic ei [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    BtnX = 10'd100; BtnY = 10'd50; blank = 1'b1;
    for (int i = 0; i < 6; i++) begin
      DrawX = 10'(100 + ox[i]); DrawY = 10'(50 + oy[i]);
      repeat (3) tick();
      n_checks++;
      if (rom_address2 !== 13'(ea[i]) || sprite_hit2 !== ei[i]) begin
        n_fail++; $display("FAIL scale_off(%0d,%0d): got addr=%0d hit=%b expected addr=%0d hit=%b", ox[i], oy[i], rom_address2, sprite_hit2, ea[i], ei[i]);
      end
      if (i == 2) begin
        n_checks++;
        if (rom_address !== 13'd2) begin n_fail++; $display("FAIL unscaled_off2: got %0d expected 2", rom_address); end
      end
      if (i == 0) begin
        n_checks++;
        if (red2 !== 4'd13 || green2 !== 4'd2 || blue2 !== 4'd0 || pal_index2 !== 4'd5) begin
          n_fail++; $display("FAIL scale_rgb: got %h%h%h idx=%0d expected d20 idx=5", red2, green2, blue2, pal_index2);
        end
      end
    end
  endtask

  task automatic test_frame_latch();
    BtnX = 10'd100; BtnY = 10'd50; blank = 1'b1;
    btn_on = 1'b1;
    DrawX = 10'd149; DrawY = 10'd99;
    repeat (3) tick();
    n_checks++;
    if (rom_address !== 13'd2499) begin n_fail++; $display("FAIL latch_hold_last: got %0d expected 2499", rom_address); end
    DrawX = 10'd100; DrawY = 10'd50;
    repeat (3) tick();
    n_checks++;
    if (rom_address !== 13'd0) begin n_fail++; $display("FAIL latch_hold_first: got %0d expected 0", rom_address); end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (rom_address !== 13'd2500) begin n_fail++; $display("FAIL frame1_first: got %0d expected 2500", rom_address); end
    DrawX = 10'd149; DrawY = 10'd99;
    repeat (3) tick();
    n_checks++;
    if (rom_address !== 13'd4999) begin n_fail++; $display("FAIL frame1_last: got %0d expected 4999", rom_address); end
    btn_on = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (rom_address !== 13'd2499) begin n_fail++; $display("FAIL frame0_again: got %0d expected 2499", rom_address); end
  endtask

  task automatic test_flash();
    logic [11:0] exp;
    BtnX = 10'd100; BtnY = 10'd50; DrawX = 10'd110; DrawY = 10'd60; blank = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({red, green, blue} !== 12'hD20) begin n_fail++; $display("FAIL flash_idle: got %h expected d20", {red, green, blue}); end
    // Hit coincident with frame_start: flash frames 1..8.
    hit = 1'b1; frame_start = 1'b1; tick(); hit = 1'b0; frame_start = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({red, green, blue} !== 12'hF64) begin n_fail++; $display("FAIL flash_f1: got %h expected f64", {red, green, blue}); end
    for (int f = 2; f <= 9; f++) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      repeat (3) tick();
      exp = (f <= 8) ? 12'hF64 : 12'hD20;
      n_checks++;
      if ({red, green, blue} !== exp) begin n_fail++; $display("FAIL flash_f%0d: got %h expected %h", f, {red, green, blue}, exp); end
    end
    // Mid-frame hit is held back until the next frame_start.
    hit = 1'b1; tick(); hit = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({red, green, blue} !== 12'hD20) begin n_fail++; $display("FAIL flash_midframe: got %h expected d20", {red, green, blue}); end
    for (int f = 1; f <= 13; f++) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      repeat (3) tick();
      if (f == 5) begin
        hit = 1'b1; tick(); hit = 1'b0;
        repeat (2) tick();
      end
      exp = (f <= 12) ? 12'hF64 : 12'hD20;
      n_checks++;
      if ({red, green, blue} !== exp) begin n_fail++; $display("FAIL retrig_f%0d: got %h expected %h", f, {red, green, blue}, exp); end
      if (f == 7) begin
        blank = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({red, green, blue} !== 12'h000 || sprite_hit !== 1'b0) begin
          n_fail++; $display("FAIL flash_blank: got rgb=%h hit=%b expected rgb=000 hit=0", {red, green, blue}, sprite_hit);
        end
        blank = 1'b1;
        repeat (3) tick();
      end
    end
  endtask

  task automatic test_reset_mid();
    BtnX = 10'd100; BtnY = 10'd50; DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1;
    btn_on = 1'b1;
    hit = 1'b1; frame_start = 1'b1; tick(); hit = 1'b0; frame_start = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (rom_address !== 13'd2500 || {red, green, blue} !== 12'hF64) begin
      n_fail++; $display("FAIL pre_reset: got addr=%0d rgb=%h expected addr=2500 rgb=f64", rom_address, {red, green, blue});
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({red, green, blue} !== 12'h000 || sprite_hit !== 1'b0 || rom_address !== 13'd0) begin
      n_fail++; $display("FAIL async_reset: got rgb=%h hit=%b addr=%0d expected 000/0/0", {red, green, blue}, sprite_hit, rom_address);
    end
    #2 reset_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (rom_address !== 13'd0 || {red, green, blue} !== 12'hD20) begin
      n_fail++; $display("FAIL post_reset_frame0: got addr=%0d rgb=%h expected addr=0 rgb=d20", rom_address, {red, green, blue});
    end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (rom_address !== 13'd2500 || {red, green, blue} !== 12'hD20) begin
      n_fail++; $display("FAIL post_reset_frame1: got addr=%0d rgb=%h expected addr=2500 rgb=d20", rom_address, {red, green, blue});
    end
    btn_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 4'd5;
    reset_n = 1'b0; DrawX = '0; DrawY = '0; BtnX = '0; BtnY = '0;
    blank = 1'b0; frame_start = 1'b0; btn_on = 1'b0; hit = 1'b0;
    pal_r = 4'd13; pal_g = 4'd2; pal_b = 4'd0;
    btn_on2 = 1'b0; rom_q2 = 4'd5;
    test_reset();
    test_bounds();
    test_transparency();
    test_scale();
    test_frame_latch();
    test_flash();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
